// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one single-bit step per clock for a programmed
// amount, framed by a start/busy/done handshake, with the last shifted-out bit as carry.
module seq_shift_unit #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               carry,
    output logic               busy,
    output logic               done
);

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_LSL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LSR = 3'd1;
    localparam logic [MODE_W-1:0] MODE_ASR = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROL = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROR = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [SHAMT_W-1:0]  cnt;
    logic [MODE_W-1:0]   mode_q;
    logic [WIDTH-1:0]    step_d;
    logic                step_c;

    // One single-bit step of the latched mode; HOLD codes leave data and carry alone.
    always_comb begin
        step_d = dout;
        step_c = carry;
        case (mode_q)
            MODE_LSL: begin
                step_d = {dout[WIDTH-2:0], 1'b0};
                step_c = dout[WIDTH-1];
            end
            MODE_LSR: begin
                step_d = {1'b0, dout[WIDTH-1:1]};
                step_c = dout[0];
            end
            MODE_ASR: begin
                step_d = {dout[WIDTH-1], dout[WIDTH-1:1]};
                step_c = dout[0];
            end
            MODE_ROL: begin
                step_d = {dout[WIDTH-2:0], dout[WIDTH-1]};
                step_c = dout[WIDTH-1];
            end
            MODE_ROR: begin
                step_d = {dout[0], dout[WIDTH-1:1]};
                step_c = dout[0];
            end
            default: begin
                step_d = dout;
                step_c = carry;
            end
        endcase
    end

    // Control FSM with busy/done registered alongside the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= '0;
            dout   <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        dout   <= din;
                        cnt    <= amount;
                        mode_q <= mode;
                        carry  <= 1'b0;
                        busy   <= 1'b1;
                        if (amount != '0) begin
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    dout  <= step_d;
                    carry <= step_c;
                    cnt   <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
